// File: rtl/register_file_pkg.sv
// Shared register-file types: default widths, address/word typedefs and
// the writeback request carried through the long-latency result buffer.
package register_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    reg_addr_t address;
    word_t     data;
  } wb_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding long-latency writeback requests.
// Push when full and pop when empty are ignored; full/empty/count are
// derived from the registered occupancy only.
module sync_fifo
  import register_file_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(wb_req_t)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == (PW+1)'(0));
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the buffer and clears stale entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= PW'(0);
      wr_ptr_q <= PW'(0);
      count_q  <= (PW+1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(0);
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: the ALU result always wins, otherwise
// the oldest buffered long-latency result is written. Also tracks pending
// long-latency destinations for decode hazard checks and stalls the ALU
// when buffered results have waited too long.
module writeback_arbiter
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = RF_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_address,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_stall,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [ADDR_WIDTH-1:0] mdu_address,
  input  logic [DATA_WIDTH-1:0] mdu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic [ADDR_WIDTH-1:0] writeback_address,
  output logic [DATA_WIDTH-1:0] writeback_data,
  output logic                  writeback_enable
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int REQ_W    = ADDR_WIDTH + DATA_WIDTH;
  localparam int FCW      = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W    = $clog2(STARVE_LIMIT) + 1;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FCW-1:0]        fifo_count_s;
  logic [REQ_W-1:0]      fifo_head_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  push_s;
  logic                  pop_s;

  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  wb_en_q, wb_en_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  stall_q, stall_d;

  // mdu_ready depends only on current occupancy, so a same-cycle pop
  // never opens a slot for a push when the buffer is full.
  assign push_s      = mdu_valid && !fifo_full_s;
  assign pop_s       = !alu_valid && !fifo_empty_s;
  assign head_addr_s = fifo_head_s[REQ_W-1:DATA_WIDTH];
  assign head_data_s = fifo_head_s[DATA_WIDTH-1:0];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({mdu_address, mdu_data}),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Source selection; writes to register 0 are consumed but not enabled.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (alu_valid) begin
      wb_en_d   = (alu_address != ADDR_WIDTH'(0));
      wb_addr_d = alu_address;
      wb_data_d = alu_data;
    end else if (pop_s) begin
      wb_en_d   = (head_addr_s != ADDR_WIDTH'(0));
      wb_addr_d = head_addr_s;
      wb_data_d = head_data_s;
    end else begin
      wb_en_d = 1'b0;
    end
  end

  // Pending-destination scoreboard: pop clears, issue sets (set wins).
  always_comb begin
    busy_d = busy_q;
    if (pop_s) begin
      busy_d[head_addr_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_valid) begin
      busy_d[issue_address] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation tracking: count non-draining cycles with data buffered.
  always_comb begin
    if ((fifo_count_s == FCW'(0)) || pop_s) begin
      starve_d = CNT_W'(0);
    end else if (starve_q != CNT_W'(STARVE_LIMIT - 1)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
    if (pop_s) begin
      stall_d = 1'b0;
    end else if (starve_q == CNT_W'(STARVE_LIMIT - 1)) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  // All arbiter state; reset drops pending bits and writeback outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_addr_q <= ADDR_WIDTH'(0);
      wb_data_q <= DATA_WIDTH'(0);
      wb_en_q   <= 1'b0;
      busy_q    <= NUM_REGS'(0);
      starve_q  <= CNT_W'(0);
      stall_q   <= 1'b0;
    end else begin
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
      busy_q    <= busy_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
    end
  end

  assign writeback_address = wb_addr_q;
  assign writeback_data    = wb_data_q;
  assign writeback_enable  = wb_en_q;
  assign alu_stall         = stall_q;
  assign mdu_ready         = !fifo_full_s;
  assign rs_busy           = busy_q[rs] && (rs != ADDR_WIDTH'(0));
  assign rt_busy           = busy_q[rt] && (rt != ADDR_WIDTH'(0));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model
// checked every falling edge, plus literal spot checks per scenario.
module tb_writeback_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_address = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_stall;
  logic          mdu_valid = 1'b0;
  logic          mdu_ready;
  logic [AW-1:0] mdu_address = '0;
  logic [DW-1:0] mdu_data = '0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_address = '0;
  logic [AW-1:0] rs = '0;
  logic [AW-1:0] rt = '0;
  logic          rs_busy, rt_busy;
  logic [AW-1:0] writeback_address;
  logic [DW-1:0] writeback_data;
  logic          writeback_enable;

  int compared = 0;
  int mismatched = 0;

  writeback_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_address(alu_address), .alu_data(alu_data),
    .alu_stall(alu_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_address(mdu_address), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_address(issue_address),
    .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .writeback_address(writeback_address), .writeback_data(writeback_data),
    .writeback_enable(writeback_enable)
  );

  always #5 clock = ~clock;

  // Reference model state.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_busy[32];
  int            m_nd;
  logic          m_stall;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_nd    = 0;
    m_stall = 1'b0;
    m_en    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_step();
    int   sz;
    bit   pop, push;
    ent_t h, n;
    sz   = mq.size();
    pop  = !alu_valid && (sz > 0);
    push = mdu_valid && (sz < DEPTH);
    check("legal_alu_vs_stall", 64'(alu_valid && m_stall), 64'(0));
    check("legal_alu_dest", 64'(alu_valid && (alu_address != 0) && m_busy[alu_address]), 64'(0));
    check("legal_issue_dest", 64'(issue_valid && m_busy[issue_address]), 64'(0));
    if (alu_valid) begin
      m_en   = (alu_address != 0);
      m_addr = alu_address;
      m_data = alu_data;
    end else if (pop) begin
      h      = mq[0];
      m_en   = (h.a != 0);
      m_addr = h.a;
      m_data = h.d;
      m_busy[h.a] = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (issue_valid && (issue_address != 0)) m_busy[issue_address] = 1'b1;
    if ((sz == 0) || pop) m_nd = 0;
    else m_nd = m_nd + 1;
    if (pop) m_stall = 1'b0;
    else if (m_nd >= LIMIT) m_stall = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      n.a = mdu_address;
      n.d = mdu_data;
      mq.push_back(n);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    check("writeback_enable", 64'(writeback_enable), 64'(m_en));
    check("writeback_address", 64'(writeback_address), 64'(m_addr));
    check("writeback_data", 64'(writeback_data), 64'(m_data));
    check("alu_stall", 64'(alu_stall), 64'(m_stall));
    check("mdu_ready", 64'(mdu_ready), 64'(mq.size() < DEPTH));
    check("rs_busy", 64'(rs_busy), 64'((rs != 0) && m_busy[rs]));
    check("rt_busy", 64'(rt_busy), 64'((rt != 0) && m_busy[rt]));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int iters;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    check("reset_wb_enable", 64'(writeback_enable), 64'(0));
    check("reset_wb_data", 64'(writeback_data), 64'(0));
    check("reset_mdu_ready", 64'(mdu_ready), 64'(1));
    check("reset_alu_stall", 64'(alu_stall), 64'(0));
    tick();

    // ALU write to r3, then to r0.
    alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'h1234_5678;
    tick();
    alu_address = 5'd0; alu_data = 32'h0000_0055;
    check("alu_r3_enable", 64'(writeback_enable), 64'(1));
    check("alu_r3_address", 64'(writeback_address), 64'(3));
    check("alu_r3_data", 64'(writeback_data), 64'h1234_5678);
    tick();
    alu_valid = 1'b0;
    check("alu_r0_enable", 64'(writeback_enable), 64'(0));
    tick();

    // ALU r1 and MDU r2 at the same edge.
    alu_valid = 1'b1; alu_address = 5'd1; alu_data = 32'hA;
    mdu_valid = 1'b1; mdu_address = 5'd2; mdu_data = 32'hB;
    tick();
    alu_valid = 1'b0; mdu_valid = 1'b0;
    check("prio_alu_first_addr", 64'(writeback_address), 64'(1));
    check("prio_alu_first_data", 64'(writeback_data), 64'hA);
    tick();
    check("prio_mdu_second_en", 64'(writeback_enable), 64'(1));
    check("prio_mdu_second_addr", 64'(writeback_address), 64'(2));
    check("prio_mdu_second_data", 64'(writeback_data), 64'hB);
    tick();

    // Scoreboard lifetime of r7.
    issue_valid = 1'b1; issue_address = 5'd7; rt = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("sb_r7_busy_after_issue", 64'(rt_busy), 64'(1));
    mdu_valid = 1'b1; mdu_address = 5'd7; mdu_data = 32'hCAFE;
    tick();
    mdu_valid = 1'b0;
    check("sb_r7_busy_while_buffered", 64'(rt_busy), 64'(1));
    tick();
    check("sb_r7_clear_after_pop", 64'(rt_busy), 64'(0));
    check("sb_r7_wb_addr", 64'(writeback_address), 64'(7));
    check("sb_r7_wb_data", 64'(writeback_data), 64'hCAFE);
    rt = 5'd0;
    tick();

    // Fill the FIFO while the ALU keeps the port busy.
    alu_valid = 1'b1; alu_address = 5'd10;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'h100 + 32'(i);
      mdu_valid = 1'b1; mdu_address = 5'(11 + i); mdu_data = 32'h2000 + 32'(i);
      tick();
    end
    check("full_mdu_ready_low", 64'(mdu_ready), 64'(0));
    mdu_address = 5'd15; mdu_data = 32'h2FFF;
    iters = 0;
    while ((alu_stall !== 1'b1) && (iters < 20)) begin
      alu_data = 32'h200 + 32'(iters);
      tick();
      mdu_valid = 1'b0;
      iters++;
    end
    check("starve_edges_to_stall", 64'(iters), 64'(5));
    check("starve_stall_high", 64'(alu_stall), 64'(1));
    check("full_still_not_ready", 64'(mdu_ready), 64'(0));
    alu_valid = 1'b0; mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_order_addr", 64'(writeback_address), 64'(11 + i));
      check("drain_order_data", 64'(writeback_data), 64'(32'h2000 + 32'(i)));
      check("drain_stall_clear", 64'(alu_stall), 64'(0));
    end
    tick();
    check("drain_no_fifth", 64'(writeback_enable), 64'(0));

    // Simultaneous set and clear of r9.
    alu_valid = 1'b1; alu_address = 5'd4; alu_data = 32'h44;
    mdu_valid = 1'b1; mdu_address = 5'd9; mdu_data = 32'h99;
    tick();
    alu_valid = 1'b0; mdu_valid = 1'b0;
    issue_valid = 1'b1; issue_address = 5'd9; rs = 5'd9;
    tick();
    issue_valid = 1'b0;
    check("setclr_r9_busy", 64'(rs_busy), 64'(1));
    check("setclr_r9_wb_addr", 64'(writeback_address), 64'(9));
    check("setclr_r9_wb_data", 64'(writeback_data), 64'h99);
    tick();

    // Reset with three buffered results and r5 pending.
    issue_valid = 1'b1; issue_address = 5'd5; rs = 5'd5;
    tick();
    issue_valid = 1'b0;
    check("rst_r5_busy_before", 64'(rs_busy), 64'(1));
    alu_valid = 1'b1; alu_address = 5'd6;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'h600 + 32'(i);
      mdu_valid = 1'b1; mdu_address = 5'(20 + i); mdu_data = 32'h3000 + 32'(i);
      tick();
    end
    mdu_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_wb_enable", 64'(writeback_enable), 64'(0));
    check("rst_mid_wb_address", 64'(writeback_address), 64'(0));
    check("rst_mid_wb_data", 64'(writeback_data), 64'(0));
    check("rst_mid_mdu_ready", 64'(mdu_ready), 64'(1));
    check("rst_mid_r5_busy", 64'(rs_busy), 64'(0));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_after_no_wb", 64'(writeback_enable), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Drives the single register-file write port (writeback_address/data/enable) that feeds both read-port RAMs and the internal forwarding path.
- Merges two result sources:
  - the in-order ALU pipeline result, which is never back-pressured;
  - the long-latency unit (load/multiply/divide) result, which uses a valid/ready handshake through a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on rs/rt hazards.

Parameters:
- DATA_WIDTH, 32, writeback data width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
- FIFO_DEPTH, 4, long-latency result buffer entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles FIFO may stay non-empty without draining before the ALU is stalled

Ports:
- clock  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result this cycle; always accepted
- alu_address  input  ADDR_WIDTH  ALU destination
- alu_data  input  DATA_WIDTH  ALU result
- alu_stall  output  1  registered; pipeline must hold ALU results next cycle
- mdu_valid  input  1  long-latency result offered
- mdu_ready  output  1  FIFO can accept (= !full, registered state)
- mdu_address  input  ADDR_WIDTH  long-latency destination
- mdu_data  input  DATA_WIDTH  long-latency result
- issue_valid  input  1  long-latency op issued; marks destination pending
- issue_address  input  ADDR_WIDTH  destination of issued op
- rs, rt  input  ADDR_WIDTH each  decode-stage source registers
- rs_busy, rt_busy  output  1 each  combinational lookup of scoreboard
- writeback_address  output  ADDR_WIDTH  to register file
- writeback_data  output  DATA_WIDTH  to register file
- writeback_enable  output  1  to register file

Behaviour:
- Reset (async, active-high):
  - writeback_address=0, writeback_data=0, writeback_enable=0, alu_stall=0, mdu_ready=1.
  - FIFO empty, scoreboard all clear, starve counter=0.
  - Reset mid-operation discards FIFO contents and pending bits.
- Writeback outputs are registered, with 1-cycle latency from the selecting edge.
- Selection at each edge:
  - if alu_valid: load ALU result;
  - else if FIFO non-empty: pop head and load it;
  - else: writeback_enable<=0, address/data hold previous value.
- Register 0: any write with address 0 produces writeback_enable=0. Both the ALU and FIFO sources are still consumed. Register 0 is never marked busy.
- MDU handshake: transfer when mdu_valid && mdu_ready at the edge.
  - mdu_ready is computed from the current count only. A pop in the same cycle does not allow a push when full.
  - Push and pop in the same cycle leaves the count unchanged.
- Latency:
  - ALU at edge k -> writeback_enable high in cycle k+1.
  - MDU accepted into empty FIFO at edge k -> earliest writeback in cycle k+2.
- Scoreboard (2**ADDR_WIDTH bits):
  - issue_valid sets bit[issue_address].
  - A FIFO pop clears bit[head address].
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never touch the scoreboard.
  - rs_busy = bit[rs] && rs!=0; rt_busy likewise.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and no pop occurs; it resets to 0 on pop or when the FIFO is empty.
  - When counter == STARVE_LIMIT-1 at an edge, alu_stall<=1.
  - alu_stall clears on the edge where the pop occurs.
- Illegal inputs (bench asserts; no RTL recovery):
  - alu_valid while alu_stall=1;
  - issue to an already busy address;
  - an ALU write to a busy address.
- FIFO order is strict FIFO; no reordering between MDU results.

Decomposition:
- Package register_file_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults;
  - typedefs reg_addr_t and word_t;
  - struct wb_req_t {reg_addr_t address; word_t data;}.
- Sub-module sync_fifo:
  - parameterised depth and width of wb_req_t;
  - push/pop/full/empty/count;
  - async active-high reset.
- The arbiter, scoreboard and starve counter stay in writeback_arbiter.

Test Plan:
- Reset: assert reset mid-stream with 3 FIFO entries and r5 busy -> all writeback outputs 0, mdu_ready=1, rs=5 gives rs_busy=0, subsequent cycles have no writeback.
- ALU only: alu_valid with r3=0x12345678 at edge k -> cycle k+1 writeback_enable=1, address 3, data 0x12345678. The same with address 0 -> writeback_enable=0.
- Priority: ALU r1=0xA and MDU r2=0xB accepted at the same edge, ALU idle afterwards -> r1 written at k+1, r2 at k+2.
- Scoreboard: issue r7, then MDU r7=0xCAFE -> rt=7 gives rt_busy=1 until the pop edge, 0 after; writeback r7=0xCAFE.
- Full FIFO:
  - push 4 MDU results while alu_valid is held high -> mdu_ready=0 after the 4th, and a 5th offer is not accepted;
  - alu_stall=1 after 8 non-draining cycles;
  - ALU dropped -> 4 writebacks in order.
- Simultaneous set/clear: issue r9 on the same edge that pops an entry for r9 -> r9 remains busy.
